// File: rtl/tile_pkg.sv
// Shared constants, state encoding and width helper for the tile map scheduler slice.
package tile_pkg;

    localparam int unsigned TILE_SIZE_LOG2 = 5;
    localparam int unsigned TILE_ID_W      = 19;
    localparam int unsigned COORD_W        = 10;

    localparam logic [TILE_ID_W-1:0] EMPTY_TILE = 19'h7FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_LOAD,
        ST_RENDER,
        ST_DONE
    } tile_state_t;

    // Width of an index covering 0..n-1; never below one bit.
    function automatic int unsigned index_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tile_map_scheduler_if.sv
// Control, map RAM and renderer signals of the tile map scheduler.
interface tile_map_scheduler_if #(
    parameter int unsigned MAP_AW = 9
);
    import tile_pkg::*;

    logic                      start;
    logic                      busy;
    logic                      done;
    logic [MAP_AW-1:0]         map_addr;
    logic [TILE_ID_W-1:0]      map_data;
    logic [TILE_ID_W-1:0]      tile_id;
    logic [COORD_W-1:0]        top;
    logic [COORD_W-1:0]        left;
    logic                      render_rstn;

    modport master (
        input  start,
        input  map_data,
        output busy,
        output done,
        output map_addr,
        output tile_id,
        output top,
        output left,
        output render_rstn
    );

    modport slave (
        output start,
        output map_data,
        input  busy,
        input  done,
        input  map_addr,
        input  tile_id,
        input  top,
        input  left,
        input  render_rstn
    );

endinterface

// File: rtl/tile_grid_cursor.sv
// Raster-order position over the tile map: column, row and linear index.
module tile_grid_cursor
    import tile_pkg::*;
#(
    parameter int unsigned COLS = 20,
    parameter int unsigned ROWS = 15
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clear,
    input  logic                                advance,
    output logic [index_width(COLS)-1:0]        col,
    output logic [index_width(ROWS)-1:0]        row,
    output logic [index_width(ROWS*COLS)-1:0]   lin,
    output logic                                last
);

    localparam int unsigned COL_W = index_width(COLS);
    localparam int unsigned ROW_W = index_width(ROWS);
    localparam int unsigned LIN_W = index_width(ROWS * COLS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
            lin <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
            lin <= '0;
        end else if (advance) begin
            lin <= lin + LIN_W'(1);
            if (col == COL_W'(COLS - 1)) begin
                col <= '0;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    assign last = (lin == LIN_W'(ROWS * COLS - 1));

endmodule

// File: rtl/tile_map_scheduler.sv
// Walks the tile map in raster order and gives the renderer a fixed run window per non-empty tile.
module tile_map_scheduler
    import tile_pkg::*;
#(
    parameter int unsigned COLS        = 20,
    parameter int unsigned ROWS        = 15,
    parameter int unsigned TILE_CYCLES = 4096,
    parameter int unsigned MAP_AW      = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    tile_map_scheduler_if.master bus
);

    localparam int unsigned COL_W = index_width(COLS);
    localparam int unsigned ROW_W = index_width(ROWS);
    localparam int unsigned LIN_W = index_width(ROWS * COLS);
    localparam int unsigned CNT_W = index_width(TILE_CYCLES);

    tile_state_t state, state_next;

    logic [CNT_W-1:0]     cnt;
    logic [COL_W-1:0]     col;
    logic [ROW_W-1:0]     row;
    logic [LIN_W-1:0]     lin;
    logic                 last;
    logic                 clear;
    logic                 advance;
    logic                 step;
    logic                 is_empty;

    logic [TILE_ID_W-1:0] tile_id_q;
    logic [COORD_W-1:0]   top_q;
    logic [COORD_W-1:0]   left_q;

    tile_grid_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .advance (advance),
        .col     (col),
        .row     (row),
        .lin     (lin),
        .last    (last)
    );

    assign is_empty = (bus.map_data == EMPTY_TILE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // step marks the end of a tile (skip from LOAD or last RENDER cycle); the advance decision folds into it.
    always_comb begin
        state_next = state;
        step       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH:  state_next = ST_WAIT;
            ST_WAIT:   state_next = ST_LOAD;
            ST_LOAD: begin
                if (is_empty) begin
                    step = 1'b1;
                end else begin
                    state_next = ST_RENDER;
                end
            end
            ST_RENDER: begin
                if (cnt == '0) begin
                    step = 1'b1;
                end
            end
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        if (step) begin
            state_next = last ? ST_DONE : ST_FETCH;
        end
    end

    assign clear   = (state == ST_IDLE);
    assign advance = step && !last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == ST_LOAD) begin
            cnt <= CNT_W'(TILE_CYCLES - 1);
        end else if (state == ST_RENDER) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile_id_q <= '0;
            top_q     <= '0;
            left_q    <= '0;
        end else if (state == ST_LOAD) begin
            tile_id_q <= bus.map_data;
            top_q     <= COORD_W'(row) << TILE_SIZE_LOG2;
            left_q    <= COORD_W'(col) << TILE_SIZE_LOG2;
        end
    end

    // lin only moves on tile boundaries, so it is already the FETCH address and stays put until the next one.
    assign bus.map_addr    = MAP_AW'(lin);
    assign bus.tile_id     = tile_id_q;
    assign bus.top         = top_q;
    assign bus.left        = left_q;
    assign bus.busy        = (state == ST_FETCH) || (state == ST_WAIT) ||
                             (state == ST_LOAD)  || (state == ST_RENDER);
    assign bus.done        = (state == ST_DONE);
    assign bus.render_rstn = (state == ST_RENDER);

endmodule

// File: tb/tb_tile_map_scheduler.sv
// Directed bench: small 3x2 map for sequencing/skip/restart/reset, default-sized map for address walk.
module tb_tile_map_scheduler;
    import tile_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    tile_map_scheduler_if #(.MAP_AW(3)) s_if();
    tile_map_scheduler_if #(.MAP_AW(9)) d_if();

    tile_map_scheduler #(
        .COLS        (3),
        .ROWS        (2),
        .TILE_CYCLES (8),
        .MAP_AW      (3)
    ) u_small (
        .clk (clk),
        .rst (rst),
        .bus (s_if)
    );

    tile_map_scheduler #(
        .COLS        (20),
        .ROWS        (15),
        .TILE_CYCLES (4096),
        .MAP_AW      (9)
    ) u_dflt (
        .clk (clk),
        .rst (rst),
        .bus (d_if)
    );

    logic [18:0] mem_s [8];
    logic [18:0] mem_d [512];

    always @(posedge clk) begin
        s_if.map_data <= mem_s[s_if.map_addr];
        d_if.map_data <= mem_d[d_if.map_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    int exp_id   [6];
    int exp_top  [6];
    int exp_left [6];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_full_expect();
        for (int k = 0; k < 6; k++) begin
            exp_id[k]   = k;
            exp_top[k]  = (k / 3) * 32;
            exp_left[k] = (k % 3) * 32;
        end
    endtask

    // Pulses start on the small DUT and follows the frame; cycle 0 is the FETCH of tile 0.
    task automatic run_small(input int n_win, input int done_at, input int poke_at);
        int   cyc;
        int   win;
        int   wlen;
        logic prev_rn;
        bit   got_done;
        s_if.start = 1'b1;
        @(negedge clk);
        s_if.start = 1'b0;
        check("busy_rise", 32'(s_if.busy), 32'd1);
        cyc = 0; win = 0; wlen = 0; prev_rn = 1'b0; got_done = 1'b0;
        while (cyc < 300 && !got_done) begin
            if (s_if.render_rstn) begin
                if (!prev_rn && win < 6) begin
                    check("tile_id", 32'(s_if.tile_id), 32'(exp_id[win]));
                    check("top",     32'(s_if.top),     32'(exp_top[win]));
                    check("left",    32'(s_if.left),    32'(exp_left[win]));
                end
                wlen++;
            end else if (prev_rn) begin
                check("win_len", 32'(wlen), 32'd8);
                win++;
                wlen = 0;
            end
            if (s_if.done) begin
                got_done = 1'b1;
                check("done_cycle", 32'(cyc), 32'(done_at));
            end
            prev_rn = s_if.render_rstn;
            if (cyc == poke_at) s_if.start = 1'b1;
            @(negedge clk);
            s_if.start = 1'b0;
            cyc++;
        end
        check("done_seen", 32'(got_done), 32'd1);
        check("windows",   32'(win),      32'(n_win));
    endtask

    initial begin
        int idle_bad;
        bit found;
        int n_reads;
        int order_bad;
        int coord_bad;
        int wins;
        int cyc;
        bit got_done;
        logic prev_rn;
        logic [8:0] last_addr;
        int d_top  [4];
        int d_left [4];

        s_if.start = 1'b0;
        d_if.start = 1'b0;
        for (int i = 0; i < 8; i++)   mem_s[i] = 19'(i);
        for (int i = 0; i < 512; i++) mem_d[i] = EMPTY_TILE;

        // Reset and idle
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (s_if.map_addr != 3'd0 || d_if.map_addr != 9'd0 || s_if.busy || d_if.busy ||
                s_if.render_rstn || d_if.render_rstn || s_if.done || d_if.done)
                idle_bad++;
        end
        check("idle_activity", 32'(idle_bad), 32'd0);
        check("rst_busy",     32'(s_if.busy),        32'd0);
        check("rst_done",     32'(s_if.done),        32'd0);
        check("rst_rstn",     32'(s_if.render_rstn), 32'd0);
        check("rst_map_addr", 32'(s_if.map_addr),    32'd0);
        check("rst_tile_id",  32'(s_if.tile_id),     32'd0);
        check("rst_top",      32'(s_if.top),         32'd0);
        check("rst_left",     32'(s_if.left),        32'd0);

        // Full small frame
        set_full_expect();
        run_small(6, 66, -1);
        check("hold_tile_id_idle", 32'(s_if.tile_id), 32'd5);
        check("hold_top_idle",     32'(s_if.top),     32'd32);
        check("hold_left_idle",    32'(s_if.left),    32'd64);

        // Empties at 2 and 4
        mem_s[2] = EMPTY_TILE;
        mem_s[4] = EMPTY_TILE;
        exp_id[0] = 0; exp_top[0] = 0;  exp_left[0] = 0;
        exp_id[1] = 1; exp_top[1] = 0;  exp_left[1] = 32;
        exp_id[2] = 3; exp_top[2] = 32; exp_left[2] = 0;
        exp_id[3] = 5; exp_top[3] = 32; exp_left[3] = 64;
        run_small(4, 50, -1);
        mem_s[2] = 19'd2;
        mem_s[4] = 19'd4;

        // Start mid-frame ignored; start right after done accepted; start during DONE ignored
        set_full_expect();
        run_small(6, 66, 20);
        run_small(6, 66, 66);
        check("done_start_idle0", 32'(s_if.busy), 32'd0);
        @(negedge clk);
        check("done_start_idle1", 32'(s_if.busy), 32'd0);

        // Reset during render of tile 3
        s_if.start = 1'b1;
        @(negedge clk);
        s_if.start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (s_if.render_rstn && s_if.tile_id == 19'd3) found = 1'b1;
            else @(negedge clk);
        end
        check("reach_tile3", 32'(found), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_rstn",     32'(s_if.render_rstn), 32'd0);
        check("mid_rst_tile_id",  32'(s_if.tile_id),     32'd0);
        check("mid_rst_busy",     32'(s_if.busy),        32'd0);
        check("mid_rst_top",      32'(s_if.top),         32'd0);
        check("mid_rst_map_addr", 32'(s_if.map_addr),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_idle", 32'(s_if.busy), 32'd0);
        run_small(6, 66, -1);

        // Default geometry: tiles 0,75,150,225 rendered, rest empty
        for (int i = 0; i < 300; i++)
            mem_d[i] = (i % 75 == 0) ? 19'($urandom_range(0, 32'h7FFFE)) : EMPTY_TILE;
        d_top[0] = 0;   d_left[0] = 0;
        d_top[1] = 96;  d_left[1] = 480;
        d_top[2] = 224; d_left[2] = 320;
        d_top[3] = 352; d_left[3] = 160;
        d_if.start = 1'b1;
        @(negedge clk);
        d_if.start = 1'b0;
        n_reads = 0; order_bad = 0; coord_bad = 0; wins = 0; cyc = 0;
        got_done = 1'b0; prev_rn = 1'b0; last_addr = '0;
        while (cyc < 20000 && !got_done) begin
            if (d_if.busy && (n_reads == 0 || d_if.map_addr != last_addr)) begin
                if (d_if.map_addr != 9'(n_reads)) order_bad++;
                last_addr = d_if.map_addr;
                n_reads++;
            end
            if (d_if.render_rstn && !prev_rn) begin
                if (d_if.top % 32 != 0 || d_if.top > 448 || d_if.left > 608) coord_bad++;
                if (wins < 4) begin
                    check("dflt_tile_id", 32'(d_if.tile_id), 32'(mem_d[wins * 75]));
                    check("dflt_top",     32'(d_if.top),     32'(d_top[wins]));
                    check("dflt_left",    32'(d_if.left),    32'(d_left[wins]));
                end
                wins++;
            end
            if (d_if.done) begin
                got_done = 1'b1;
                check("dflt_done_cycle", 32'(cyc), 32'd17284);
            end
            prev_rn = d_if.render_rstn;
            @(negedge clk);
            cyc++;
        end
        check("dflt_done_seen",  32'(got_done),  32'd1);
        check("dflt_reads",      32'(n_reads),   32'd300);
        check("dflt_addr_order", 32'(order_bad), 32'd0);
        check("dflt_last_addr",  32'(last_addr), 32'd299);
        check("dflt_coords",     32'(coord_bad), 32'd0);
        check("dflt_windows",    32'(wins),      32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tile_map_scheduler.md
# tile_map_scheduler

Frame-level sequencer that sits directly upstream of the per-tile renderer. On a `start` pulse it walks a ROWS×COLS tile map in raster order, reads each entry from a synchronous map RAM, and presents `tile_id`/`top`/`left` to the renderer. It releases the renderer's active-low reset for a fixed TILE_CYCLES window per tile, so each 32×32 tile is drawn into the framebuffer. Entries equal to EMPTY_TILE are skipped without rendering.

## Interface
Parameters:
- COLS, 20, tiles per row; COLS*32 ≤ 1024
- ROWS, 15, tile rows per frame; ROWS*32 ≤ 1024
- TILE_CYCLES, 4096, cycles the renderer runs per tile; must be ≥ 4096
- MAP_AW, 9, map RAM address width; 2^MAP_AW ≥ ROWS*COLS

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to render a frame; ignored while busy
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at end of frame
- map_addr  out  MAP_AW  tile map RAM read address
- map_data  in  19  tile map RAM read data; valid 1 cycle after map_addr
- tile_id  out  19  tile index to the renderer
- top  out  10  tile pixel row = row*32
- left  out  10  tile pixel column = col*32
- render_rstn  out  1  active-low reset to the renderer; high only in RENDER

## Operation
- States: IDLE, FETCH, WAIT, LOAD, RENDER, DONE.
- IDLE: render_rstn=0, busy=0. If start=1 → FETCH. Clear col, row, and lin to 0 (lin = linear map index).
- FETCH: map_addr=lin → WAIT.
- WAIT: RAM latency cycle → LOAD.
- LOAD: latch tile_id=map_data, top=row<<5, left=col<<5.
  - If map_data == EMPTY_TILE (19'h7FFFF), skip directly to the advance step.
  - Otherwise load cnt=TILE_CYCLES-1 → RENDER.
- RENDER: render_rstn=1, decrement cnt. When cnt==0 → advance.
- Advance, taken in the same cycle as leaving LOAD (skip) or RENDER:
  - If lin==ROWS*COLS-1 → DONE.
  - Else lin+1. col+1, wrapping to 0 at COLS with row+1. → FETCH.
- DONE: done=1 for one cycle → IDLE.
- tile_id, top and left are held stable through RENDER. They keep their last values in IDLE.
- Arithmetic: col, row and lin are sized by $clog2. top and left are zero-extended shifts, so no overflow is possible under the parameter constraints.

## Timing
- Reset values: busy=0, done=0, render_rstn=0, map_addr=0, tile_id=0, top=0, left=0, state=IDLE.
- start → FETCH on the next edge. busy rises in the same cycle FETCH begins.
- Rendered tile: FETCH + WAIT + LOAD + TILE_CYCLES = TILE_CYCLES+3 cycles.
- Skipped tile: 3 cycles, with render_rstn staying 0.
- render_rstn falls for at least 3 cycles between consecutive rendered tiles, which guarantees a renderer restart.
- Full frame with no empties: ROWS*COLS*(TILE_CYCLES+3) cycles from FETCH to DONE. The default is 300*4099.
- start during busy or DONE: ignored, with no queueing.
- start arriving in the cycle after DONE (IDLE): accepted.
- rst mid-frame: immediately returns to IDLE with all outputs at reset values. render_rstn=0 aborts the renderer mid-tile.
- Last tile empty: DONE follows its LOAD directly.

## Structure
- Shared package `tile_pkg`:
  - TILE_SIZE_LOG2=5
  - EMPTY_TILE=19'h7FFFF
  - TILE_ID_W=19
  - COORD_W=10
  - the state enum
- One sub-module, `tile_grid_cursor`: holds col, row and lin, with clear/advance inputs and a last flag. The scheduler owns the FSM and the cycle counter.

## Test plan
- Reset, then idle 10 cycles → every output at its reset value, no map reads.
- ROWS=2, COLS=3, TILE_CYCLES=8, map = 0..5, start → 6 render windows of 8 cycles each with render_rstn=1. Tiles in order: (id,top,left) = (0,0,0), (1,0,32), (2,0,64), (3,32,0), (4,32,32), (5,32,64). done pulses at cycle 6*11 after FETCH.
- Same setup with map[2]=map[4]=EMPTY_TILE → only 4 render windows. done arrives 2*8 cycles earlier, and render_rstn stays 0 through the skips.
- start pulsed again mid-frame, then again the cycle after done → the first is ignored, the second starts a new frame with lin=0.
- rst asserted during the RENDER of tile 3 → next cycle IDLE, render_rstn=0, tile_id=0. A later start restarts from tile (0,0,0).
- Default parameters with a random map → exactly 300 map reads, addresses 0..299 ascending. Every top is a multiple of 32 and ≤448; every left ≤608.
